// File: rtl/col_demux_fifo_if.sv
// -----------------------------------------------------------------------------
// col_demux_fifo_if
// Bundle of the handshake and data signals of the 1:4 column demultiplexer.
//   master : upstream producer / downstream consumers (drives i_*, reads o_*)
//   slave  : the col_demux_fifo block itself
// Signals:
//   i_flush          synchronous clear of all lanes and the round-robin pointer
//   i_data/i_valid   input column word and its valid
//   o_ready          block can accept i_data this cycle
//   i_sel/i_auto     explicit lane select / use round-robin pointer
//   o_data1..4       head word of each lane
//   o_valid[3:0]     lane non-empty flags
//   i_ready[3:0]     per-lane pop requests from downstream
//   o_wrap           one-cycle pulse after the pointer wraps 3 -> 0
//   i_bcast          (COL_DEMUX_BCAST_EN only) write the word into all lanes
// -----------------------------------------------------------------------------
interface col_demux_fifo_if #(
  parameter int COL = 3
);
`ifdef COL_DEMUX_BCAST_EN
  logic           i_bcast;
`endif
  logic           i_flush;
  logic [COL-1:0] i_data;
  logic           i_valid;
  logic           o_ready;
  logic [1:0]     i_sel;
  logic           i_auto;
  logic [COL-1:0] o_data1;
  logic [COL-1:0] o_data2;
  logic [COL-1:0] o_data3;
  logic [COL-1:0] o_data4;
  logic [3:0]     o_valid;
  logic [3:0]     i_ready;
  logic           o_wrap;

  modport master (
`ifdef COL_DEMUX_BCAST_EN
    output i_bcast,
`endif
    output i_flush, i_data, i_valid, i_sel, i_auto, i_ready,
    input  o_ready, o_data1, o_data2, o_data3, o_data4, o_valid, o_wrap
  );

  modport slave (
`ifdef COL_DEMUX_BCAST_EN
    input  i_bcast,
`endif
    input  i_flush, i_data, i_valid, i_sel, i_auto, i_ready,
    output o_ready, o_data1, o_data2, o_data3, o_data4, o_valid, o_wrap
  );
endinterface

// File: rtl/col_demux_fifo.sv
// -----------------------------------------------------------------------------
// col_demux_fifo
// Sequential 1:4 column demultiplexer with a small FIFO per output lane.
// Each accepted COL-bit word is routed to lane T = i_auto ? ptr : i_sel and
// queued there; downstream PE columns drain each lane independently.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      col_demux_fifo_if.slave (handshake, lane outputs, flush, wrap)
//
// Optional feature: define COL_DEMUX_BCAST_EN to add bus.i_bcast, which writes
// one accepted word into all four lanes at once (needs all lanes non-full).
// -----------------------------------------------------------------------------
module col_demux_fifo #(
  parameter int COL   = 3,
  parameter int DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  col_demux_fifo_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 bcast;
  logic [1:0]           ptr_reg;
  logic                 wrap_reg;
  logic [1:0]           tgt;
  logic [3:0]           full;
  logic [3:0]           valid;
  logic                 ready;
  logic                 accept;
  logic                 advance;
  logic [3:0][COL-1:0]  head;

`ifdef COL_DEMUX_BCAST_EN
  assign bcast = bus.i_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign tgt     = bus.i_auto ? ptr_reg : bus.i_sel;
  // Ready depends only on registered fill state and the select inputs, never
  // on the downstream i_ready, so a full lane needs one cycle after a pop.
  assign ready   = ~bus.i_flush & (bcast ? ~|full : ~full[tgt]);
  assign accept  = bus.i_valid & ready;
  assign advance = accept & bus.i_auto & ~bcast;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [COL-1:0] mem_reg [DEPTH];
      logic [AW-1:0]  rd_ptr_reg;
      logic [AW-1:0]  wr_ptr_reg;
      logic [CW-1:0]  count_reg;
      logic [COL-1:0] head_reg;
      logic [AW-1:0]  rd_ptr_inc;
      logic           push;
      logic           pop;

      assign push       = accept & (bcast | (tgt == 2'(gi)));
      assign pop        = valid[gi] & bus.i_ready[gi];
      assign rd_ptr_inc = rd_ptr_reg + AW'(1);
      assign full[gi]   = (count_reg == CW'(DEPTH));
      assign valid[gi]  = (count_reg != '0);
      assign head[gi]   = head_reg;

      // Storage needs no reset; occupancy alone decides what is valid.
      always_ff @(posedge i_clk) begin
        if (push) begin
          mem_reg[wr_ptr_reg] <= bus.i_data;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
          head_reg   <= '0;
        end else if (bus.i_flush) begin
          // Flush discards any same-cycle pop; the head word is left as is.
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_inc;
          case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
          // The head register holds the entry at the read pointer. When the
          // next entry was only just pushed it comes straight from i_data;
          // when the lane drains completely the last word is kept on display.
          if (pop) begin
            if (count_reg > CW'(1)) begin
              head_reg <= mem_reg[rd_ptr_inc];
            end else if (push) begin
              head_reg <= bus.i_data;
            end
          end else if (push && (count_reg == '0)) begin
            head_reg <= bus.i_data;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_reg  <= 2'd0;
      wrap_reg <= 1'b0;
    end else if (bus.i_flush) begin
      ptr_reg  <= 2'd0;
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= advance & (ptr_reg == 2'd3);
      if (advance) begin
        ptr_reg <= ptr_reg + 2'd1;
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = valid;
  assign bus.o_data1 = head[0];
  assign bus.o_data2 = head[1];
  assign bus.o_data3 = head[2];
  assign bus.o_data4 = head[3];
  assign bus.o_wrap  = wrap_reg;

endmodule

// File: tb/tb_col_demux_fifo.sv
// -----------------------------------------------------------------------------
// tb_col_demux_fifo
// Self-checking bench for col_demux_fifo: a directed vector table (inputs plus
// the outputs expected during that cycle), hand-written reset / broadcast
// sequences, and a randomized phase checked against per-lane scoreboard queues.
// -----------------------------------------------------------------------------
module tb_col_demux_fifo;
  localparam int COL   = 3;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  col_demux_fifo_if #(.COL(COL)) bus ();

  col_demux_fifo #(.COL(COL), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0][COL-1:0] dout;
  assign dout = {bus.o_data4, bus.o_data3, bus.o_data2, bus.o_data1};

  typedef struct {
    logic           fl;
    logic           v;
    logic [COL-1:0] d;
    logic [1:0]     sel;
    logic           au;
    logic [3:0]     rdy;
    logic           er;
    logic [3:0]     ev;
    int             ed [4];
    logic           ew;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard model for the random phase
  int   sbq [4][$];
  logic [1:0] m_ptr;
  logic       m_wrap;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic v, input logic [COL-1:0] d,
                       input logic [1:0] sel, input logic au, input logic [3:0] rdy);
    bus.i_flush = fl;
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_sel   = sel;
    bus.i_auto  = au;
    bus.i_ready = rdy;
`ifdef COL_DEMUX_BCAST_EN
    bus.i_bcast = 1'b0;
`endif
  endtask

  task automatic check_outs(input string tag, input logic er, input logic [3:0] ev,
                            input int d1, input int d2, input int d3, input int d4,
                            input logic ew);
    chk({tag, ".ready"}, int'(bus.o_ready), int'(er));
    chk({tag, ".valid"}, int'(bus.o_valid), int'(ev));
    chk({tag, ".data1"}, int'(bus.o_data1), d1);
    chk({tag, ".data2"}, int'(bus.o_data2), d2);
    chk({tag, ".data3"}, int'(bus.o_data3), d3);
    chk({tag, ".data4"}, int'(bus.o_data4), d4);
    chk({tag, ".wrap"},  int'(bus.o_wrap),  int'(ew));
  endtask

  function automatic vec_t mk(input logic fl, input logic v, input int d, input int sel,
                              input logic au, input logic [3:0] rdy, input logic er,
                              input logic [3:0] ev, input int d1, input int d2,
                              input int d3, input int d4, input logic ew);
    vec_t r;
    r.fl = fl; r.v = v; r.d = COL'(d); r.sel = 2'(sel); r.au = au; r.rdy = rdy;
    r.er = er; r.ev = ev; r.ed[0] = d1; r.ed[1] = d2; r.ed[2] = d3; r.ed[3] = d4;
    r.ew = ew;
    return r;
  endfunction

  initial begin
    drive(1'b0, 1'b0, '0, 2'd0, 1'b0, 4'b0000);

    // Reset asserted mid-cycle: outputs clear immediately
    #2 rst_n = 1'b0;
    #1 check_outs("reset", 1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Each row: inputs for one cycle and the outputs expected during that cycle
    //              fl v  d sel au rdy      er  ev       d1 d2 d3 d4 wrap
    // explicit routing to lane 3, then drain it
    vecs.push_back(mk(0, 1, 5, 2, 0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 4'b0100, 0, 0, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 1, 4'b0100, 0, 0, 5, 0, 0));
    // round robin 1,2,3,4 then 7 behind 1; wrap after the fourth word
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'b0000, 1, 4'b0000, 0, 0, 5, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 4'b0000, 1, 4'b0001, 1, 0, 5, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 1, 4'b0000, 1, 4'b0011, 1, 2, 5, 0, 0));
    vecs.push_back(mk(0, 1, 4, 0, 1, 4'b0000, 1, 4'b0111, 1, 2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 7, 0, 1, 4'b0000, 1, 4'b1111, 1, 2, 3, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 1, 4'b1111, 1, 2, 3, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b1111, 0, 4'b1111, 1, 2, 3, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 1, 4'b0001, 7, 2, 3, 4, 0));
    // lane 1 full / backpressure: third word held until one cycle after a pop
    vecs.push_back(mk(0, 1, 6, 0, 0, 4'b0000, 1, 4'b0000, 7, 2, 3, 4, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0, 4'b0000, 1, 4'b0001, 6, 2, 3, 4, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 4'b0000, 0, 4'b0001, 6, 2, 3, 4, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 4'b0001, 0, 4'b0001, 6, 2, 3, 4, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 4'b0000, 1, 4'b0001, 5, 2, 3, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 4'b0001, 5, 2, 3, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 0, 4'b0001, 5, 2, 3, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0001, 1, 4'b0001, 2, 2, 3, 4, 0));
    // simultaneous push/pop on lane 2 keeps level at one
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 1, 4'b0000, 2, 2, 3, 4, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 4'b0010, 1, 4'b0010, 2, 1, 3, 4, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 1, 4'b0010, 2, 3, 3, 4, 0));
    // fill lanes, pointer to 2, then flush with a same-cycle push and pops
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'b0010, 1, 4'b0010, 2, 3, 3, 4, 0));
    vecs.push_back(mk(0, 1, 6, 2, 0, 4'b0000, 1, 4'b0001, 1, 3, 3, 4, 0));
    vecs.push_back(mk(0, 1, 5, 0, 1, 4'b0000, 1, 4'b0101, 1, 3, 6, 4, 0));
    vecs.push_back(mk(1, 1, 7, 0, 1, 4'b1111, 0, 4'b0111, 1, 5, 6, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 1, 4'b0000, 1, 5, 6, 4, 0));
    vecs.push_back(mk(0, 1, 3, 0, 1, 4'b0000, 1, 4'b0000, 1, 5, 6, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 1, 4'b0001, 3, 5, 6, 4, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].sel, vecs[i].au, vecs[i].rdy);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].er, vecs[i].ev,
                 vecs[i].ed[0], vecs[i].ed[1], vecs[i].ed[2], vecs[i].ed[3], vecs[i].ew);
    end

    // Async reset in the middle of a transfer
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd5, 2'd2, 1'b0, 4'b0000);
    @(posedge clk);
    drive(1'b0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0000);
    #2 rst_n = 1'b0;
    #1 check_outs("midrst", 1'b1, 4'b0000, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 3'd6, 2'd3, 1'b1, 4'b0000);
    #1 chk("postrst.ready", int'(bus.o_ready), 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 4'b0000);
    #1 check_outs("postrst", 1'b1, 4'b0001, 6, 0, 0, 0, 1'b0);

`ifdef COL_DEMUX_BCAST_EN
    // Broadcast after a flush: all lanes get the word, no wrap pulse
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 4'b0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd6, 2'd3, 1'b1, 4'b0000);
    bus.i_bcast = 1'b1;
    #1 chk("bcast.ready", int'(bus.o_ready), 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 4'b0000);
    #1 check_outs("bcast", 1'b1, 4'b1111, 6, 6, 6, 6, 1'b0);
`endif

    // Randomized phase against the scoreboard
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr  = 2'd0;
    m_wrap = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic           fl, v, au, er, acc;
      logic [COL-1:0] d;
      logic [1:0]     sel, tgt;
      logic [3:0]     rdy, ev;
      @(negedge clk);
      fl  = ($urandom_range(0, 31) == 0);
      v   = ($urandom_range(0, 3) != 0);
      d   = COL'($urandom_range(0, 7));
      sel = 2'($urandom_range(0, 3));
      au  = 1'($urandom_range(0, 1));
      rdy = 4'($urandom_range(0, 15));
      drive(fl, v, d, sel, au, rdy);
      #1;
      tgt = au ? m_ptr : sel;
      er  = !fl && (sbq[tgt].size() < DEPTH);
      for (int k = 0; k < 4; k++) ev[k] = (sbq[k].size() != 0);
      chk("rnd.ready", int'(bus.o_ready), int'(er));
      chk("rnd.valid", int'(bus.o_valid), int'(ev));
      chk("rnd.wrap",  int'(bus.o_wrap),  int'(m_wrap));
      for (int k = 0; k < 4; k++) begin
        if (sbq[k].size() != 0) begin
          chk($sformatf("rnd.data%0d", k + 1), int'(dout[k]), sbq[k][0]);
        end
      end
      acc = v && er;
      if (fl) begin
        for (int k = 0; k < 4; k++) sbq[k].delete();
        m_ptr  = 2'd0;
        m_wrap = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (ev[k] && rdy[k]) void'(sbq[k].pop_front());
        end
        if (acc) sbq[tgt].push_back(int'(d));
        m_wrap = acc && au && (m_ptr == 2'd3);
        if (acc && au) m_ptr = m_ptr + 2'd1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
